// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//   Shares one single-port data memory between the pipeline load/store port
//   (core) and an auxiliary master (aux), e.g. a UART loader or debug path.
//   Aux normally yields to the core, but it is forced through after
//   STARVE_MAX consecutive core grants while it waits. This bounds aux latency.
//   Accesses outside DEPTH words are consumed without touching the memory,
//   and the next cycle they answer with err=1.
//
// Ports
//   clk, reset                    posedge clock, asynchronous active-low reset
//   core_req/we/addr/wdata/mask   core request (we=1 write, byte address)
//   core_gnt, core_stall          accepted this cycle / waiting on arbitration
//   core_rvalid/rdata/err         response, one cycle after grant
//   aux_*                         same as core, but with no stall output
//   mem_addr/wdata/mask           memory address, write data and byte mask
//   mem_wr_en, mem_cs             active-low write strobe and chip select
//   mem_rd_en                     active-high read strobe
//   mem_rdata                     memory read data, valid in the cycle after access
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int DEPTH      = 512,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic [3:0]  core_mask,
    output logic        core_gnt,
    output logic        core_stall,
    output logic        core_rvalid,
    output logic [31:0] core_rdata,
    output logic        core_err,

    input  logic        aux_req,
    input  logic        aux_we,
    input  logic [31:0] aux_addr,
    input  logic [31:0] aux_wdata,
    input  logic [3:0]  aux_mask,
    output logic        aux_gnt,
    output logic        aux_rvalid,
    output logic [31:0] aux_rdata,
    output logic        aux_err,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr_en,
    output logic        mem_rd_en,
    output logic        mem_cs,
    output logic [3:0]  mem_mask,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0]  SMAX    = 4'(STARVE_MAX);
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    typedef enum logic [2:0] {
        OWN_NONE,
        OWN_CORE_RD,
        OWN_AUX_RD,
        OWN_CORE_ERR,
        OWN_AUX_ERR
    } owner_t;

    owner_t      owner;
    owner_t      owner_next;
    logic [3:0]  starve_cnt;

    logic        any_gnt;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_mask;
    logic        sel_oor;

    // Grants are held off while reset is asserted, so nothing is accepted
    // before the response registers are live.
    always_comb begin
        aux_gnt    = reset & aux_req & (~core_req | (starve_cnt == SMAX));
        core_gnt   = reset & core_req & ~aux_gnt;
        core_stall = core_req & ~core_gnt;
        any_gnt    = aux_gnt | core_gnt;
    end

    always_comb begin
        sel_we    = aux_gnt ? aux_we    : core_we;
        sel_addr  = aux_gnt ? aux_addr  : core_addr;
        sel_wdata = aux_gnt ? aux_wdata : core_wdata;
        sel_mask  = aux_gnt ? aux_mask  : core_mask;
        sel_oor   = (sel_addr[31:2] >= DEPTH_W);
    end

    // Memory drive. An out-of-range winner keeps the chip deselected. Its
    // address and data still pass through, but the memory ignores them.
    always_comb begin
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_cs    = 1'b1;
        mem_wr_en = 1'b1;
        mem_rd_en = 1'b0;
        mem_mask  = 4'd0;
        if (any_gnt) begin
            mem_addr  = sel_addr;
            mem_wdata = sel_wdata;
            if (!sel_oor) begin
                mem_cs    = 1'b0;
                mem_wr_en = ~sel_we;
                mem_rd_en = ~sel_we;
                mem_mask  = sel_we ? sel_mask : 4'd0;
            end
        end
    end

    // The winner of this cycle decides who owns the response slot next cycle.
    // In-range writes need no response.
    always_comb begin
        owner_next = OWN_NONE;
        if (aux_gnt) begin
            if (sel_oor)      owner_next = OWN_AUX_ERR;
            else if (!sel_we) owner_next = OWN_AUX_RD;
        end else if (core_gnt) begin
            if (sel_oor)      owner_next = OWN_CORE_ERR;
            else if (!sel_we) owner_next = OWN_CORE_RD;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner       <= OWN_NONE;
            core_rvalid <= 1'b0;
            core_err    <= 1'b0;
            aux_rvalid  <= 1'b0;
            aux_err     <= 1'b0;
            starve_cnt  <= 4'd0;
        end else begin
            owner       <= owner_next;
            core_rvalid <= (owner_next == OWN_CORE_RD) | (owner_next == OWN_CORE_ERR);
            core_err    <= (owner_next == OWN_CORE_ERR);
            aux_rvalid  <= (owner_next == OWN_AUX_RD) | (owner_next == OWN_AUX_ERR);
            aux_err     <= (owner_next == OWN_AUX_ERR);
            // Count core wins while aux waits. Saturation keeps aux forced
            // through until it actually wins.
            if (aux_gnt || !aux_req)
                starve_cnt <= 4'd0;
            else if (core_gnt && (starve_cnt != SMAX))
                starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Read data is steered only to the port that owns a read response.
    // An error response returns zero.
    always_comb begin
        core_rdata = (owner == OWN_CORE_RD) ? mem_rdata : 32'd0;
        aux_rdata  = (owner == OWN_AUX_RD)  ? mem_rdata : 32'd0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter.
//   The bench owns a synchronous single-port memory model that drives
//   mem_rdata. A transaction-level reference model at negedge predicts every
//   DUT output from the arbitration rules, a reference word array and a
//   one-deep response slot. Literal checks in the stimulus process pin the
//   reference model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int DEPTH      = 512;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req, core_we, core_gnt, core_stall, core_rvalid, core_err;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic [3:0]  core_mask;
    logic        aux_req, aux_we, aux_gnt, aux_rvalid, aux_err;
    logic [31:0] aux_addr, aux_wdata, aux_rdata;
    logic [3:0]  aux_mask;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_wr_en, mem_rd_en, mem_cs;
    logic [3:0]  mem_mask;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_mask(core_mask), .core_gnt(core_gnt),
        .core_stall(core_stall), .core_rvalid(core_rvalid),
        .core_rdata(core_rdata), .core_err(core_err),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr),
        .aux_wdata(aux_wdata), .aux_mask(aux_mask), .aux_gnt(aux_gnt),
        .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata), .aux_err(aux_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en),
        .mem_rd_en(mem_rd_en), .mem_cs(mem_cs), .mem_mask(mem_mask),
        .mem_rdata(mem_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory behind the arbiter ----------------
    logic [31:0] env_mem [DEPTH];

    always @(posedge clk) begin
        if (!mem_cs && (mem_addr[31:2] < DEPTH)) begin
            if (!mem_wr_en)
                for (int b = 0; b < 4; b++)
                    if (mem_mask[b]) env_mem[mem_addr[10:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            if (mem_rd_en) mem_rdata <= env_mem[mem_addr[10:2]];
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [DEPTH];
    int          m_port;      // 0 none, 1 core, 2 aux: owner of the next response
    bit          m_err;
    logic [31:0] m_data;
    int          m_waits;     // consecutive core wins while aux waits

    always @(negedge clk) begin
        bit          aw, cw, we, oor;
        logic [31:0] addr, wdata;
        logic [3:0]  mask;
        int          idx;
        if (!reset) begin
            m_port = 0; m_err = 0; m_data = 0; m_waits = 0;
            chk("rst_core_gnt", {31'd0, core_gnt}, 0);
            chk("rst_aux_gnt", {31'd0, aux_gnt}, 0);
            chk("rst_core_rvalid", {31'd0, core_rvalid}, 0);
            chk("rst_aux_rvalid", {31'd0, aux_rvalid}, 0);
            chk("rst_mem_cs", {31'd0, mem_cs}, 1);
            chk("rst_mem_wr_en", {31'd0, mem_wr_en}, 1);
            chk("rst_mem_rd_en", {31'd0, mem_rd_en}, 0);
            chk("rst_mem_mask", {28'd0, mem_mask}, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
        end else begin
            aw = aux_req && (!core_req || m_waits >= STARVE_MAX);
            cw = core_req && !aw;
            chk("core_gnt", {31'd0, core_gnt}, {31'd0, cw});
            chk("aux_gnt", {31'd0, aux_gnt}, {31'd0, aw});
            chk("core_stall", {31'd0, core_stall}, {31'd0, core_req && !cw});
            chk("core_rvalid", {31'd0, core_rvalid}, {31'd0, m_port == 1});
            chk("core_err", {31'd0, core_err}, {31'd0, m_port == 1 && m_err});
            chk("core_rdata", core_rdata, (m_port == 1 && !m_err) ? m_data : 32'd0);
            chk("aux_rvalid", {31'd0, aux_rvalid}, {31'd0, m_port == 2});
            chk("aux_err", {31'd0, aux_err}, {31'd0, m_port == 2 && m_err});
            chk("aux_rdata", aux_rdata, (m_port == 2 && !m_err) ? m_data : 32'd0);

            we    = aw ? aux_we : core_we;
            addr  = aw ? aux_addr : core_addr;
            wdata = aw ? aux_wdata : core_wdata;
            mask  = aw ? aux_mask : core_mask;
            oor   = (addr / 4) >= DEPTH;
            idx   = int'(addr / 4);
            if (aw || cw) begin
                chk("mem_addr", mem_addr, addr);
                chk("mem_wdata", mem_wdata, wdata);
                chk("mem_cs", {31'd0, mem_cs}, {31'd0, oor});
                chk("mem_wr_en", {31'd0, mem_wr_en}, {31'd0, oor || !we});
                chk("mem_rd_en", {31'd0, mem_rd_en}, {31'd0, !oor && !we});
                if (!oor) chk("mem_mask", {28'd0, mem_mask}, we ? {28'd0, mask} : 32'd0);
            end else begin
                chk("idle_mem_cs", {31'd0, mem_cs}, 1);
                chk("idle_mem_wr_en", {31'd0, mem_wr_en}, 1);
                chk("idle_mem_rd_en", {31'd0, mem_rd_en}, 0);
                chk("idle_mem_mask", {28'd0, mem_mask}, 0);
                chk("idle_mem_addr", mem_addr, 0);
            end

            // Advance the model across the coming posedge.
            m_port = 0; m_err = 0; m_data = 0;
            if (aw || cw) begin
                if (oor) begin
                    m_port = aw ? 2 : 1; m_err = 1;
                end else if (we) begin
                    for (int b = 0; b < 4; b++)
                        if (mask[b]) ref_mem[idx][b*8 +: 8] = wdata[b*8 +: 8];
                end else begin
                    m_port = aw ? 2 : 1; m_data = ref_mem[idx];
                end
            end
            if (aw || !aux_req) m_waits = 0;
            else if (cw && m_waits < STARVE_MAX) m_waits = m_waits + 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    // Issue one request on a port, hold it until granted (bounded), then drop it.
    // Returns one cycle after the grant cycle, just after the posedge.
    task automatic op(input bit is_aux, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] mask);
        bit got = 0;
        if (is_aux) begin
            aux_req = 1; aux_we = we; aux_addr = addr; aux_wdata = wdata; aux_mask = mask;
        end else begin
            core_req = 1; core_we = we; core_addr = addr; core_wdata = wdata; core_mask = mask;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((is_aux && aux_gnt) || (!is_aux && core_gnt)) begin
                got = 1;
                break;
            end
            step();
        end
        chk("op_granted", {31'd0, got}, 1);
        step();
        if (is_aux) aux_req = 0; else core_req = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] seq10;
        logic [4:0] seq5;
        for (int i = 0; i < DEPTH; i++) begin
            env_mem[i] = 32'd0;
            ref_mem[i] = 32'd0;
        end
        mem_rdata = 32'd0;
        reset = 0;
        core_req = 1; core_we = 0; core_addr = 0; core_wdata = 0; core_mask = 0;
        aux_req = 0; aux_we = 0; aux_addr = 0; aux_wdata = 0; aux_mask = 0;

        // Reset held with a pending core request
        repeat (2) @(negedge clk);
        chk("lit_rst_cs", {31'd0, mem_cs}, 1);
        chk("lit_rst_wr_en", {31'd0, mem_wr_en}, 1);
        chk("lit_rst_rd_en", {31'd0, mem_rd_en}, 0);
        chk("lit_rst_core_gnt", {31'd0, core_gnt}, 0);
        chk("lit_rst_core_rvalid", {31'd0, core_rvalid}, 0);
        step();
        reset = 1;
        @(negedge clk);
        chk("lit_release_core_gnt", {31'd0, core_gnt}, 1);
        step();
        core_req = 0;

        // Full-word write followed by read-back
        core_req = 1; core_we = 1; core_addr = 32'h4; core_wdata = 32'hDEADBEEF; core_mask = 4'hF;
        @(negedge clk);
        chk("lit_wr_gnt", {31'd0, core_gnt}, 1);
        chk("lit_wr_en", {31'd0, mem_wr_en}, 0);
        chk("lit_wr_cs", {31'd0, mem_cs}, 0);
        chk("lit_wr_mask", {28'd0, mem_mask}, 32'hF);
        step();
        core_req = 0;
        op(0, 0, 32'h4, 32'h0, 4'h0);
        @(negedge clk);
        chk("lit_rd_rvalid", {31'd0, core_rvalid}, 1);
        chk("lit_rd_rdata", core_rdata, 32'hDEADBEEF);

        // Byte-masked write
        op(0, 1, 32'h10, 32'h11223344, 4'hF);
        op(0, 1, 32'h10, 32'h0000AB00, 4'b0010);
        op(0, 0, 32'h10, 32'h0, 4'h0);
        @(negedge clk);
        chk("lit_mask_rdata", core_rdata, 32'h1122AB44);

        // Continuous contention: aux is forced through after STARVE_MAX core wins
        step();
        core_req = 1; core_we = 0; core_addr = 32'h4;
        aux_req = 1; aux_we = 0; aux_addr = 32'h10;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seq10[i] = aux_gnt;
            chk("lit_stall_vs_aux", {31'd0, core_stall}, {31'd0, aux_gnt});
            step();
        end
        core_req = 0; aux_req = 0;
        chk("lit_grant_seq", {22'd0, seq10}, 32'h210);
        step();

        // Aux out-of-range read (word 512)
        op(1, 0, 32'h800, 32'h0, 4'h0);
        @(negedge clk);
        chk("lit_oor_aux_rvalid", {31'd0, aux_rvalid}, 1);
        chk("lit_oor_aux_err", {31'd0, aux_err}, 1);
        chk("lit_oor_aux_rdata", aux_rdata, 0);
        chk("lit_oor_core_rvalid", {31'd0, core_rvalid}, 0);

        // Core out-of-range write must not alias into the array
        op(0, 1, 32'h1004, 32'hCAFEF00D, 4'hF);
        @(negedge clk);
        chk("lit_oor_wr_err", {31'd0, core_err}, 1);
        chk("lit_oor_wr_rvalid", {31'd0, core_rvalid}, 1);
        op(0, 0, 32'h4, 32'h0, 4'h0);
        @(negedge clk);
        chk("lit_no_alias_rdata", core_rdata, 32'hDEADBEEF);
        step();

        // Build up starvation, then reset during an outstanding core read
        core_req = 1; core_we = 0; core_addr = 32'h4;
        aux_req = 1; aux_we = 0; aux_addr = 32'h10;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lit_pre_rst_core_gnt", {31'd0, core_gnt}, 1);
            if (i < 2) step();
        end
        #2;
        reset = 0; core_req = 0; aux_req = 0;
        step();
        step();
        reset = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("lit_post_rst_rvalid", {31'd0, core_rvalid}, 0);
            step();
        end
        core_req = 1; aux_req = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            seq5[i] = aux_gnt;
            step();
        end
        core_req = 0; aux_req = 0;
        chk("lit_post_rst_seq", {27'd0, seq5}, 32'h10);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port data memory.
- Shares the memory between the pipeline load/store port (core) and an auxiliary master (aux), such as the UART loader or debug path.
- Drives the memory's native control encoding: write-enable active-low, chip-select active-low, rd_en active-high, 4-bit byte mask, byte address.
- Routes read data and validity back to the winning requester, stalls the core when it loses, and guarantees bounded aux latency.

Parameters:
- DEPTH, 512: memory depth in 32-bit words; word index is addr[31:2].
- STARVE_MAX, 4: max consecutive core grants while aux is pending before aux is forced to win (1..15).

Ports:
- clk  input  1  clock, posedge domain
- reset  input  1  asynchronous, active-low reset
- core_req  input  1  core access request
- core_we  input  1  1 = write, 0 = read (active-high at this interface)
- core_addr  input  32  byte address
- core_wdata  input  32  write data
- core_mask  input  4  byte enables for writes
- core_gnt  output  1  request accepted this cycle
- core_stall  output  1  core_req & ~core_gnt
- core_rvalid  output  1  read data valid, one cycle after grant
- core_rdata  output  32  read data
- core_err  output  1  out-of-range access response, with rvalid timing
- aux_req, aux_we, aux_addr, aux_wdata, aux_mask, aux_gnt, aux_rvalid, aux_rdata, aux_err: same widths and meanings for the aux port (aux has no stall output)
- mem_addr  output  32  to memory Addr
- mem_wdata  output  32  to memory dataWrite
- mem_wr_en  output  1  active-low write strobe
- mem_rd_en  output  1  active-high read strobe
- mem_cs  output  1  active-low chip select
- mem_mask  output  4  byte mask
- mem_rdata  input  32  memory readData, valid by the posedge after the access cycle

Behaviour:
- Reset (reset=0, async): starve_cnt=0, owner=NONE, all rvalid/err=0.
- Reset values of the memory-side outputs during reset and when idle: mem_cs=1, mem_wr_en=1, mem_rd_en=0, mem_mask=0, mem_addr=0, mem_wdata=0.
- Grant is combinational from the current req inputs plus registered starve_cnt:
  - aux wins if aux_req & (~core_req | starve_cnt==STARVE_MAX);
  - otherwise core wins if core_req.
  - At most one gnt per cycle; gnt is asserted only while the matching req is high.
- Memory drive: combinational mux of the winner's signals.
  - mem_wr_en = ~(we), and mem_mask = mask on writes; mem_mask = 0 on reads.
  - mem_rd_en = ~we; mem_cs = 0.
  - mem_addr and mem_wdata pass through unchanged.
- Out-of-range (addr[31:2] >= DEPTH):
  - The request is still granted (consumed), but mem_cs=1, mem_wr_en=1, mem_rd_en=0.
  - The next cycle returns err=1, rvalid=1, rdata=0 on that port. This applies to both reads and writes.
- FSM register owner ∈ {NONE, CORE_RD, AUX_RD, CORE_ERR, AUX_ERR}, loaded every posedge from the current grant.
  - A granted in-range write loads NONE, so writes produce no response.
  - owner drives the registered rvalid/err for exactly one cycle.
  - Back-to-back grants pipeline with no bubble.
- Read response: {port}_rdata = mem_rdata when owner=={port}_RD; otherwise 0.
  - Read latency = 1 cycle (grant in cycle N, rvalid in cycle N+1).
- starve_cnt, updated each posedge:
  - cleared if aux granted or ~aux_req;
  - incremented, saturating at STARVE_MAX, when core is granted while aux_req=1.
- Simultaneous requests, with STARVE_MAX=4 and both ports requesting continuously: core, core, core, core, aux, then repeat.
- Requesters must hold req and all request fields stable until gnt. Dropping req before gnt cancels the request; no side effect.
- Reset mid-read: the pending rvalid is discarded and never emitted after reset release.

Test Plan:
- Reset low with core_req=1 → mem_cs=1, mem_wr_en=1, mem_rd_en=0, all gnt/rvalid=0. Release reset → core_gnt=1 in the same cycle.
- core write, addr 0x4, wdata 0xDEADBEEF, mask 4'b1111. Then core read, addr 0x4 → write cycle: mem_wr_en=0, mem_cs=0, mem_mask=F. Read: core_rvalid=1 with core_rdata=0xDEADBEEF one cycle after grant.
- core write, mask 4'b0010, wdata 0x0000AB00, to a word preset to 0x11223344; then read → rdata 0x1122AB44.
- core_req and aux_req held high for 10 cycles, STARVE_MAX=4 → grants C,C,C,C,A,C,C,C,C,A. core_stall=1 exactly in the aux cycles.
- aux read of addr 0x800 (word 512, DEPTH=512) → aux_gnt=1, mem_cs=1 in that cycle. Next cycle aux_rvalid=1, aux_err=1, aux_rdata=0. core unaffected.
- core read granted, reset asserted before the next posedge, released 2 cycles later → core_rvalid never pulses and starve_cnt=0.
